// File: rtl/snd_mailbox.sv
// Main-CPU -> sound-CPU command mailbox: per-channel FIFOs, NMI request, full/overflow status.
// Optional reply path enabled by defining SND_MAILBOX_REPLY_EN.
module snd_mailbox #(
    parameter int unsigned DW       = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NMI_MODE = 0,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  m_cen,
    input  logic                  m_wr,
    input  logic                  m_rd,
    input  logic [CH_W-1:0]       m_ch,
    input  logic [DW-1:0]         m_din,
    output logic [2*CHANNELS-1:0] m_status,
    input  logic                  m_ovf_clr,
    input  logic                  s_cen,
    input  logic                  s_rd,
    input  logic [CH_W-1:0]       s_ch,
    output logic [DW-1:0]         s_dout,
    output logic [CHANNELS-1:0]   s_empty,
    input  logic                  s_ack,
`ifdef SND_MAILBOX_REPLY_EN
    input  logic                  s_wr,
    input  logic [DW-1:0]         s_din,
    output logic [DW-1:0]         m_reply,
    output logic                  m_reply_valid,
`endif
    output logic                  s_nmi
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DW-1:0]         mem_q    [CHANNELS][DEPTH];
    logic [DW-1:0]         mem_d    [CHANNELS][DEPTH];
    logic [PW-1:0]         wr_ptr_q [CHANNELS];
    logic [PW-1:0]         wr_ptr_d [CHANNELS];
    logic [PW-1:0]         rd_ptr_q [CHANNELS];
    logic [PW-1:0]         rd_ptr_d [CHANNELS];
    logic [CW-1:0]         count_q  [CHANNELS];
    logic [CW-1:0]         count_d  [CHANNELS];
    logic [DW-1:0]         last_q   [CHANNELS];
    logic [DW-1:0]         last_d   [CHANNELS];
    logic [CHANNELS-1:0]   ovf_q, ovf_d, full_d;
    logic [2*CHANNELS-1:0] status_q, status_d;
    logic                  nmi_q, nmi_d;

    logic                  m_ch_ok, s_ch_ok;
    logic [CHANNELS-1:0]   push_req, pop_req, push_ok, pop_ok;

    assign m_ch_ok = (32'(m_ch) < CHANNELS);
    assign s_ch_ok = (32'(s_ch) < CHANNELS);

    // Pop is resolved first so a full channel popped this cycle can still accept a push.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            push_req[c] = m_cen && m_wr && m_ch_ok && (m_ch == CH_W'(c));
            pop_req[c]  = s_cen && s_rd && s_ch_ok && (s_ch == CH_W'(c));
            pop_ok[c]   = pop_req[c] && (count_q[c] != '0);
            push_ok[c]  = push_req[c] && ((count_q[c] != FULL_CNT) || pop_ok[c]);
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        ovf_d    = (m_cen && m_ovf_clr) ? '0 : ovf_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (pop_ok[c]) begin
                last_d[c]   = mem_q[c][rd_ptr_q[c]];
                rd_ptr_d[c] = (rd_ptr_q[c] == LAST_PTR) ? '0 : rd_ptr_q[c] + PW'(1);
            end
            if (push_ok[c]) begin
                mem_d[c][wr_ptr_q[c]] = m_din;
                wr_ptr_d[c] = (wr_ptr_q[c] == LAST_PTR) ? '0 : wr_ptr_q[c] + PW'(1);
            end
            if (push_req[c] && !push_ok[c]) begin
                ovf_d[c] = 1'b1;
            end
            count_d[c] = count_q[c] + CW'(push_ok[c]) - CW'(pop_ok[c]);
            full_d[c]  = (count_d[c] == FULL_CNT);
        end
        status_d = {ovf_d, full_d};
    end

    always_comb begin
        if (NMI_MODE == 0) begin
            // A push in the same cycle as an acknowledge wins so no command goes unnoticed.
            if (|push_ok) begin
                nmi_d = 1'b1;
            end else if (s_cen && s_ack) begin
                nmi_d = 1'b0;
            end else begin
                nmi_d = nmi_q;
            end
        end else begin
            nmi_d = |(~s_empty);
        end
    end

    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
                last_q[c]   <= '0;
            end
            ovf_q    <= '0;
            status_q <= '0;
            nmi_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            status_q <= status_d;
            nmi_q    <= nmi_d;
        end
    end

    // Empty channel rereads the last popped word, like the old single latch.
    always_comb begin
        s_dout = '0;
        if (s_ch_ok) begin
            if (count_q[s_ch] == '0) begin
                s_dout = last_q[s_ch];
            end else begin
                s_dout = mem_q[s_ch][rd_ptr_q[s_ch]];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            s_empty[c] = (count_q[c] == '0);
        end
    end

    assign m_status = status_q;
    assign s_nmi    = nmi_q;

`ifdef SND_MAILBOX_REPLY_EN
    logic [DW-1:0] reply_q, reply_d;
    logic          reply_valid_q, reply_valid_d;

    always_comb begin
        reply_d       = reply_q;
        reply_valid_d = reply_valid_q;
        if (s_cen && s_wr) begin
            reply_d       = s_din;
            reply_valid_d = 1'b1;
        end else if (m_cen && m_rd) begin
            reply_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            reply_q       <= '0;
            reply_valid_q <= 1'b0;
        end else begin
            reply_q       <= reply_d;
            reply_valid_q <= reply_valid_d;
        end
    end

    assign m_reply       = reply_q;
    assign m_reply_valid = reply_valid_q;
`else
    logic unused_m_rd;
    assign unused_m_rd = m_rd;
`endif

endmodule
